sprite_frame_scheduler: RTL and testbench

Per-frame sequencer between the SPI sprite draw queue and the sprite blitter. On each frame boundary it waits for framebuffer clear to finish, then dequeues sprite commands one at a time and hands each to the blitter with a start/done handshake. It stops when the queue is empty or the per-frame cap is reached. It sits in the pixel_clk domain, between the spi_driver queue interface and the sprite drawing datapath.

---
 rtl/sprite_frame_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_sprite_frame_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_frame_scheduler.sv
// Per-frame sprite sequencer: on each frame boundary waits for the framebuffer
// clear, then pops sprite commands from the FWFT queue one at a time and hands
// each to the blitter with a start/done handshake until the queue is empty or
// the per-frame cap is reached.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | out of reset, waiting for the first frame edge
// SETTLE     | counting down SETTLE_CYCLES after the frame edge
// CLEARWAIT  | waiting for fb_resetting to drop
// FETCH      | decide: cap reached / queue empty -> DONE, else pop and latch
// ISSUE      | sprite latched, waiting for blit_busy low to pulse blit_start
// WAIT       | blit running, waiting for blit_done
// DONE       | frame's work finished, waiting for the next frame edge
module sprite_frame_scheduler #(
    parameter int MAX_SPRITES   = 64,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_sync,
    input  logic        fb_resetting,
    output logic        q_dequeue,
    input  logic        q_is_empty,
    input  logic [7:0]  q_sprite_id,
    input  logic [15:0] q_sprite_x,
    input  logic [15:0] q_sprite_y,
    input  logic [7:0]  q_sprite_scale,
    output logic        blit_start,
    output logic [7:0]  blit_id,
    output logic [15:0] blit_x,
    output logic [15:0] blit_y,
    output logic [7:0]  blit_scale,
    input  logic        blit_busy,
    input  logic        blit_done,
    output logic        frame_active,
    output logic [7:0]  sprites_drawn,
    output logic [7:0]  sprites_dropped,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CLEARWAIT,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [7:0]       MAX_CAP     = 8'(MAX_SPRITES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic             frame_sync_q, frame_sync_d;
    logic             pending_q, pending_d;
    logic             q_dequeue_q, q_dequeue_d;
    logic             blit_start_q, blit_start_d;
    logic [7:0]       blit_id_q, blit_id_d;
    logic [15:0]      blit_x_q, blit_x_d;
    logic [15:0]      blit_y_q, blit_y_d;
    logic [7:0]       blit_scale_q, blit_scale_d;
    logic             frame_active_q, frame_active_d;
    logic [7:0]       drawn_q, drawn_d;
    logic [7:0]       dropped_q, dropped_d;
    logic             overrun_q, overrun_d;

    logic             frame_edge;
    logic             restart;

    assign frame_edge = frame_sync & ~frame_sync_q;

    // Next-state and registered-output computation for the scheduler FSM.
    always_comb begin
        state_d        = state_q;
        settle_d       = settle_q;
        frame_sync_d   = frame_sync;
        pending_d      = pending_q;
        q_dequeue_d    = 1'b0;
        blit_start_d   = 1'b0;
        blit_id_d      = blit_id_q;
        blit_x_d       = blit_x_q;
        blit_y_d       = blit_y_q;
        blit_scale_d   = blit_scale_q;
        frame_active_d = frame_active_q;
        drawn_d        = drawn_q;
        dropped_d      = dropped_q;
        overrun_d      = overrun_q;
        restart        = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (frame_edge) begin
                    state_d        = S_SETTLE;
                    settle_d       = SETTLE_LOAD;
                    drawn_d        = 8'd0;
                    frame_active_d = 1'b1;
                    pending_d      = 1'b0;
                end
            end
            S_SETTLE: begin
                if (frame_edge) begin
                    restart = 1'b1;
                end else if (settle_q <= CNT_W'(1)) begin
                    settle_d = '0;
                    state_d  = S_CLEARWAIT;
                end else begin
                    settle_d = settle_q - CNT_W'(1);
                end
            end
            S_CLEARWAIT: begin
                if (frame_edge) begin
                    restart = 1'b1;
                end else if (!fb_resetting) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (frame_edge) begin
                    restart = 1'b1;
                end else if (drawn_q == MAX_CAP || q_is_empty) begin
                    // Anything left in the queue waits for the next frame.
                    state_d        = S_DONE;
                    frame_active_d = 1'b0;
                end else begin
                    q_dequeue_d  = 1'b1;
                    blit_id_d    = q_sprite_id;
                    blit_x_d     = q_sprite_x;
                    blit_y_d     = q_sprite_y;
                    blit_scale_d = q_sprite_scale;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (frame_edge) begin
                    // The latched sprite was never started, so it is lost.
                    if (dropped_q != 8'hFF) begin
                        dropped_d = dropped_q + 8'd1;
                    end
                    restart = 1'b1;
                end else if (!blit_busy) begin
                    blit_start_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // A running blit is never aborted; a late frame edge is
                // remembered and acted on once the blitter reports done.
                if (frame_edge) begin
                    overrun_d = 1'b1;
                    pending_d = 1'b1;
                end
                if (blit_done) begin
                    if (pending_q || frame_edge) begin
                        restart = 1'b1;
                    end else begin
                        drawn_d = drawn_q + 8'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (restart) begin
            state_d        = S_SETTLE;
            settle_d       = SETTLE_LOAD;
            drawn_d        = 8'd0;
            frame_active_d = 1'b1;
            overrun_d      = 1'b1;
            pending_d      = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            settle_q       <= '0;
            frame_sync_q   <= 1'b0;
            pending_q      <= 1'b0;
            q_dequeue_q    <= 1'b0;
            blit_start_q   <= 1'b0;
            blit_id_q      <= 8'd0;
            blit_x_q       <= 16'd0;
            blit_y_q       <= 16'd0;
            blit_scale_q   <= 8'd0;
            frame_active_q <= 1'b0;
            drawn_q        <= 8'd0;
            dropped_q      <= 8'd0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            frame_sync_q   <= frame_sync_d;
            pending_q      <= pending_d;
            q_dequeue_q    <= q_dequeue_d;
            blit_start_q   <= blit_start_d;
            blit_id_q      <= blit_id_d;
            blit_x_q       <= blit_x_d;
            blit_y_q       <= blit_y_d;
            blit_scale_q   <= blit_scale_d;
            frame_active_q <= frame_active_d;
            drawn_q        <= drawn_d;
            dropped_q      <= dropped_d;
            overrun_q      <= overrun_d;
        end
    end

    assign q_dequeue       = q_dequeue_q;
    assign blit_start      = blit_start_q;
    assign blit_id         = blit_id_q;
    assign blit_x          = blit_x_q;
    assign blit_y          = blit_y_q;
    assign blit_scale      = blit_scale_q;
    assign frame_active    = frame_active_q;
    assign sprites_drawn   = drawn_q;
    assign sprites_dropped = dropped_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Directed bench for sprite_frame_scheduler with a FWFT queue model, a
// framebuffer-clear model and a blitter model, all updated on the falling edge.
module tb_sprite_frame_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_sync;
    logic        fb_resetting;
    logic        q_dequeue;
    logic        q_is_empty;
    logic [7:0]  q_sprite_id;
    logic [15:0] q_sprite_x;
    logic [15:0] q_sprite_y;
    logic [7:0]  q_sprite_scale;
    logic        blit_start;
    logic [7:0]  blit_id;
    logic [15:0] blit_x;
    logic [15:0] blit_y;
    logic [7:0]  blit_scale;
    logic        blit_busy;
    logic        blit_done;
    logic        frame_active;
    logic [7:0]  sprites_drawn;
    logic [7:0]  sprites_dropped;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    logic [7:0]  qid [0:31];
    logic [15:0] qx  [0:31];
    logic [15:0] qy  [0:31];
    logic [7:0]  qs  [0:31];
    int          qhead = 0;
    int          qtail = 0;

    logic [7:0]  ids [0:63];
    int          ndeq, nstart, viol;
    int          fb_cnt, bcnt, blit_dly;
    bit          auto_blit;

    always #5 clock = ~clock;

    assign q_is_empty     = (qhead == qtail);
    assign q_sprite_id    = qid[qhead[4:0]];
    assign q_sprite_x     = qx[qhead[4:0]];
    assign q_sprite_y     = qy[qhead[4:0]];
    assign q_sprite_scale = qs[qhead[4:0]];

    sprite_frame_scheduler #(.MAX_SPRITES(4), .SETTLE_CYCLES(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .frame_sync     (frame_sync),
        .fb_resetting   (fb_resetting),
        .q_dequeue      (q_dequeue),
        .q_is_empty     (q_is_empty),
        .q_sprite_id    (q_sprite_id),
        .q_sprite_x     (q_sprite_x),
        .q_sprite_y     (q_sprite_y),
        .q_sprite_scale (q_sprite_scale),
        .blit_start     (blit_start),
        .blit_id        (blit_id),
        .blit_x         (blit_x),
        .blit_y         (blit_y),
        .blit_scale     (blit_scale),
        .blit_busy      (blit_busy),
        .blit_done      (blit_done),
        .frame_active   (frame_active),
        .sprites_drawn  (sprites_drawn),
        .sprites_dropped(sprites_dropped),
        .overrun        (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: move to the falling edge, observe outputs, advance the models.
    task automatic step();
        @(negedge clock);
        if (blit_done) blit_done = 1'b0;
        if (q_dequeue) begin
            if (q_is_empty) viol++;
            ndeq++;
            qhead++;
        end
        if (blit_start) begin
            ids[nstart[5:0]] = blit_id;
            nstart++;
            if (fb_resetting) viol++;
            if (auto_blit) begin
                blit_busy = 1'b1;
                bcnt      = blit_dly;
            end
        end else if (auto_blit && blit_busy) begin
            bcnt--;
            if (bcnt == 0) begin
                blit_busy = 1'b0;
                blit_done = 1'b1;
            end
        end
        if (fb_cnt > 0) fb_cnt--;
        fb_resetting = (fb_cnt != 0);
    endtask

    task automatic q_load(input int id0, input int n, input int x, input int y, input int s);
        qhead = 0;
        qtail = n;
        for (int i = 0; i < n; i++) begin
            qid[i] = 8'(id0 + i);
            qx[i]  = 16'(x);
            qy[i]  = 16'(y);
            qs[i]  = 8'(s);
        end
    endtask

    task automatic zero_counts();
        ndeq   = 0;
        nstart = 0;
        viol   = 0;
    endtask

    task automatic frame(input int fb_cycles);
        frame_sync   = 1'b1;
        fb_cnt       = fb_cycles;
        fb_resetting = (fb_cycles != 0);
        step();
        frame_sync = 1'b0;
    endtask

    task automatic wait_frame_end(input string tag);
        int n = 0;
        while (frame_active && n < 400) begin
            step();
            n++;
        end
        check(tag, 32'(frame_active), 32'd0);
    endtask

    task automatic wait_starts(input string tag, input int target);
        int n = 0;
        while (nstart < target && n < 200) begin
            step();
            n++;
        end
        check(tag, nstart, target);
    endtask

    task automatic reset_dut();
        reset        = 1'b0;
        blit_busy    = 1'b0;
        blit_done    = 1'b0;
        fb_cnt       = 0;
        fb_resetting = 1'b0;
        frame_sync   = 1'b0;
        auto_blit    = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        int hi;
        int n;
        int n0;
        int d0;

        reset        = 1'b0;
        frame_sync   = 1'b0;
        fb_resetting = 1'b0;
        blit_busy    = 1'b0;
        blit_done    = 1'b0;
        fb_cnt       = 0;
        bcnt         = 0;
        blit_dly     = 4;
        auto_blit    = 1'b1;
        zero_counts();

        // 1: reset held with frame_sync toggling
        for (int i = 0; i < 3; i++) begin
            frame_sync = ~frame_sync;
            step();
        end
        check("rst_ctl", {28'd0, q_dequeue, blit_start, frame_active, overrun}, 32'd0);
        check("rst_fields", {blit_id, blit_scale, blit_x}, 32'd0);
        check("rst_y_cnt", {blit_y, sprites_drawn, sprites_dropped}, 32'd0);
        check("rst_no_deq", ndeq, 0);
        frame_sync = 1'b0;
        reset      = 1'b1;
        step();
        step();
        check("post_rst_idle", 32'(frame_active), 32'd0);

        // 2: three sprites, clear busy 10 cycles, blit takes 4 cycles
        q_load(5, 3, 100, 50, 2);
        zero_counts();
        frame(10);
        check("t2_active", 32'(frame_active), 32'd1);
        wait_frame_end("t2_end");
        check("t2_deq", ndeq, 3);
        check("t2_starts", nstart, 3);
        check("t2_ids", {8'd0, ids[0], ids[1], ids[2]}, 32'h00050607);
        check("t2_drawn", 32'(sprites_drawn), 32'd3);
        check("t2_no_early", viol, 0);
        check("t2_xy", {blit_x, blit_y}, {16'd100, 16'd50});
        check("t2_scale", 32'(blit_scale), 32'd2);
        check("t2_empty", 32'(q_is_empty), 32'd1);

        // 3: cap of 4 with 10 queued, two frames
        q_load(20, 10, 7, 9, 1);
        zero_counts();
        frame(3);
        wait_frame_end("t3a_end");
        check("t3a_starts", nstart, 4);
        check("t3a_deq", ndeq, 4);
        check("t3a_ids", {ids[0], ids[1], ids[2], ids[3]}, 32'h14151617);
        check("t3a_drawn", 32'(sprites_drawn), 32'd4);
        check("t3a_not_empty", 32'(q_is_empty), 32'd0);
        frame(0);
        wait_frame_end("t3b_end");
        check("t3b_starts", nstart, 8);
        check("t3b_ids", {ids[4], ids[5], ids[6], ids[7]}, 32'h18191a1b);
        check("t3b_drawn", 32'(sprites_drawn), 32'd4);
        check("t3b_not_empty", 32'(q_is_empty), 32'd0);
        check("t3_contract", viol, 0);

        // 4: empty queue, clear busy 5 cycles
        qhead = 0;
        qtail = 0;
        zero_counts();
        frame(5);
        hi = frame_active ? 1 : 0;
        n  = 0;
        while (frame_active && n < 50) begin
            step();
            n++;
            if (frame_active) hi++;
        end
        check("t4_active_len", hi, 6);
        check("t4_deq", ndeq, 0);
        check("t4_starts", nstart, 0);
        check("t4_drawn", 32'(sprites_drawn), 32'd0);
        check("t4_no_overrun", 32'(overrun), 32'd0);

        // 5a: frame edge during the second blit, done 6 cycles later
        q_load(40, 3, 1, 2, 3);
        zero_counts();
        blit_dly  = 4;
        auto_blit = 1'b1;
        frame(0);
        wait_starts("t5a_start2", 2);
        auto_blit = 1'b0;
        check("t5a_drawn1", 32'(sprites_drawn), 32'd1);
        step();
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        check("t5a_overrun", 32'(overrun), 32'd1);
        check("t5a_drawn_hold", 32'(sprites_drawn), 32'd1);
        n0 = nstart;
        d0 = ndeq;
        step();
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        step();
        step();
        step();
        check("t5a_no_start", nstart, n0);
        blit_done = 1'b1;
        blit_busy = 1'b0;
        step();
        check("t5a_drawn0", 32'(sprites_drawn), 32'd0);
        check("t5a_active", 32'(frame_active), 32'd1);
        check("t5a_no_deq", ndeq, d0);
        auto_blit = 1'b1;
        wait_frame_end("t5a_end");
        check("t5a_final_drawn", 32'(sprites_drawn), 32'd1);
        check("t5a_final_starts", nstart, 3);
        check("t5a_last_id", 32'(ids[2]), 32'd42);

        // 5b: frame edge while a latched sprite waits on a busy blitter
        reset_dut();
        check("t5b_rst_overrun", 32'(overrun), 32'd0);
        q_load(50, 1, 0, 0, 0);
        zero_counts();
        auto_blit = 1'b0;
        blit_busy = 1'b1;
        frame(0);
        n = 0;
        while (ndeq < 1 && n < 50) begin
            step();
            n++;
        end
        check("t5b_deq", ndeq, 1);
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        check("t5b_dropped", 32'(sprites_dropped), 32'd1);
        check("t5b_overrun", 32'(overrun), 32'd1);
        wait_frame_end("t5b_end");
        blit_busy = 1'b0;
        step();
        step();
        check("t5b_no_start", nstart, 0);
        check("t5b_dropped_hold", 32'(sprites_dropped), 32'd1);
        check("t5b_drawn", 32'(sprites_drawn), 32'd0);

        // 6: blit_done and frame edge in the same WAIT cycle
        reset_dut();
        q_load(60, 2, 0, 0, 0);
        zero_counts();
        auto_blit = 1'b0;
        blit_busy = 1'b0;
        frame(0);
        wait_starts("t6_start1", 1);
        blit_busy = 1'b1;
        step();
        check("t6_pre_overrun", 32'(overrun), 32'd0);
        d0         = ndeq;
        frame_sync = 1'b1;
        blit_done  = 1'b1;
        blit_busy  = 1'b0;
        step();
        frame_sync = 1'b0;
        check("t6_overrun", 32'(overrun), 32'd1);
        check("t6_drawn0", 32'(sprites_drawn), 32'd0);
        check("t6_active", 32'(frame_active), 32'd1);
        check("t6_no_deq", {31'd0, q_dequeue}, 32'd0);
        check("t6_deq_count", ndeq, d0);
        auto_blit = 1'b1;
        wait_frame_end("t6_end");
        check("t6_final_drawn", 32'(sprites_drawn), 32'd1);
        check("t6_last_id", 32'(ids[1]), 32'd61);
        check("t6_contract", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
